accel_io_sequencer: RTL and testbench
=====================================

# accel_io_sequencer

Top-level load/run/unload sequencer for the accelerator, between the 16-bit pad input stream / 8-bit pad output stream and the accelerator's instruction and data memories. After reset it captures five 16-bit configuration words, assembles 32-bit instructions and input words from pairs of 16-bit transfers and writes them into memory, then launches the core. When the core finishes, it reads the result window and serializes it out byte by byte. After each frame it loops back to accept a new input frame, keeping the configuration and instructions already loaded.

## Interface
Parameters:
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 32, memory word width; fixed at 2×IN_WIDTH and 4×OUT_WIDTH
- IN_WIDTH, 16, input stream width
- OUT_WIDTH, 8, output stream width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  IN_WIDTH  input stream payload
- in_vld  in  1  input payload valid
- in_rdy  out  1  sequencer can accept input
- out_data  out  OUT_WIDTH  output byte
- out_vld  out  1  output byte valid
- out_rdy  in  1  downstream accepts byte
- instr_wen / instr_wadr / instr_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  instruction memory write port
- data_wen / data_wadr / data_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  data memory write port
- data_ren / data_radr  out  1 / ADDR_WIDTH  data memory read request
- data_rdata  in  DATA_WIDTH  read data, valid 1 cycle after data_ren
- start  out  1  one-cycle core launch pulse
- done  in  1  one-cycle core completion pulse

## Operation
- A transfer occurs when in_vld && in_rdy, or when out_vld && out_rdy.
- CFG: five transfers are loaded in order into cfg[0..4], the last of which is then followed by INSTR:
  - cfg[0] = instr_max_wadr
  - cfg[1] = input_max_wadr
  - cfg[2] = input_wadr_offset
  - cfg[3] = output_max_adr
  - cfg[4] = output_adr_offset
- INSTR: words are assembled low half first, then high half. Each word is written at address k, for k = 0..instr_max_wadr. After word instr_max_wadr is written, go to INPUT.
- INPUT: words are assembled the same way. Each word is written to data memory at input_wadr_offset + k, for k = 0..input_max_wadr. After the last word, go to RUN.
- RUN: start pulses high for exactly one cycle on the first RUN cycle. The sequencer then waits for done, then goes to OUTPUT.
- OUTPUT: for k = 0..output_max_adr, the sequencer reads output_adr_offset + k and emits 4 bytes, least significant byte first. After the last byte of the last word, go to INPUT.
- Address sums wrap modulo 2^ADDR_WIDTH. Counters compare for equality against their max, so max = 0 means exactly one word.
- done is ignored outside RUN. in_vld is ignored while in_rdy = 0.

## Timing
- Reset values:
  - state = CFG; cfg regs, counters and half-word latch = 0.
  - in_rdy = 0, out_vld = 0, out_data = 0, start = 0.
  - All wen/ren = 0; all addresses and data = 0.
- in_rdy is registered. It is 1 from the first edge with rst_n high, in CFG, INSTR and INPUT. It drops at the same edge that accepts the final INPUT half-word, so no extra transfer is taken.
- Write latency: wen, address and data are high/valid for exactly one cycle, the cycle after the high-half transfer. Back-to-back transfers give one write every 2 cycles.
- Output word sequence, with T = the data_ren cycle:
  - T: data_ren = 1.
  - T+1: data_rdata is captured.
  - T+2 onward: out_vld = 1 with byte 0.
  - out_data is held stable while out_vld && !out_rdy.
- The next read is issued the cycle after byte 3 is transferred. With out_rdy held at 1, throughput is 6 cycles per word.
- start is asserted in the cycle after the transition into RUN.
- Reset asserted mid-operation: at the next edge, return to CFG with all reset values. Partially assembled words are discarded and no memory write is issued.

## Structure
- Package accel_io_pkg holds:
  - the state enum {CFG, INSTR, INPUT, RUN, OUT_RD, OUT_WAIT, OUT_SEND};
  - NUM_CONFIGS = 5;
  - config index constants CFG_INSTR_MAX, CFG_IN_MAX, CFG_IN_OFS, CFG_OUT_MAX, CFG_OUT_OFS.
- Sub-module word_serializer: loads one DATA_WIDTH word and emits it as OUT_WIDTH valid/ready beats, LSB first, and pulses last_o on the final beat. The main FSM, config registers and assembly logic stay in accel_io_sequencer.

## Test plan
- Config load: stream 0x007D, 0x0017, 0x07D0, 0x0017, 0x07E8 → cfg regs match these values; state is INSTR after the fifth transfer.
- Instruction assembly: send 0x5678, then 0x1234 → one cycle of instr_wen = 1 with instr_wadr = 0 and instr_wdata = 0x12345678. After 126 words, no further instr_wen and the state is INPUT.
- Input load with in_vld gaps: 24 words → data_wen at 0x07D0..0x07E7. in_rdy drops after the 48th half-word, and start pulses once.
- Run hold: hold done low for 100 cycles → in_rdy = 0, out_vld = 0, no reads. Pulse done → data_ren at 0x07E8.
- Output with backpressure: data_rdata = 0xAABBCCDD, and out_rdy toggles every cycle → bytes DD, CC, BB, AA, each held stable until accepted. After 24 words the state returns to INPUT with in_rdy = 1.
- Reset mid-INPUT, after a low half only: no data_wen is issued; in_rdy = 0 during reset, then the CFG sequence restarts correctly.

Source files
------------

// File: rtl/accel_io_pkg.sv
// Shared state encoding and configuration-slot constants for the accelerator
// load/run/unload sequencer.
package accel_io_pkg;

  typedef enum logic [2:0] {
    CFG      = 3'd0,
    INSTR    = 3'd1,
    INPUT    = 3'd2,
    RUN      = 3'd3,
    OUT_RD   = 3'd4,
    OUT_WAIT = 3'd5,
    OUT_SEND = 3'd6
  } seq_state_e;

  localparam int NUM_CONFIGS = 5;

  localparam int CFG_INSTR_MAX = 0;
  localparam int CFG_IN_MAX    = 1;
  localparam int CFG_IN_OFS    = 2;
  localparam int CFG_OUT_MAX   = 3;
  localparam int CFG_OUT_OFS   = 4;

endpackage

// File: rtl/word_serializer.sv
// Splits one memory word into OUT_WIDTH valid/ready beats, least significant
// beat first; last_o marks the accepted final beat.
module word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [OUT_WIDTH-1:0]  beat_data_o,
  output logic                  beat_vld_o,
  input  logic                  beat_rdy_i,
  output logic                  last_o
);
  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = $clog2(BEATS);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [BW-1:0]         beat_r;
  logic                  vld_r;
  logic                  fire_s;

  assign fire_s      = vld_r && beat_rdy_i;
  assign last_o      = fire_s && (beat_r == BW'(BEATS - 1));
  assign beat_data_o = shift_r[OUT_WIDTH-1:0];
  assign beat_vld_o  = vld_r;

  // Word shifter: the next beat moves into the low lane on each accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_r <= '0;
      beat_r  <= '0;
      vld_r   <= 1'b0;
    end else if (load_i) begin
      shift_r <= word_i;
      beat_r  <= '0;
      vld_r   <= 1'b1;
    end else if (fire_s) begin
      shift_r <= shift_r >> OUT_WIDTH;
      beat_r  <= beat_r + BW'(1);
      vld_r   <= !last_o;
    end
  end

endmodule

// File: rtl/accel_io_sequencer.sv
// Load/run/unload sequencer: config capture, instruction and input loading,
// core launch, and byte-serial readout of the result window.
module accel_io_sequencer
  import accel_io_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  instr_wen,
  output logic [ADDR_WIDTH-1:0] instr_wadr,
  output logic [DATA_WIDTH-1:0] instr_wdata,
  output logic                  data_wen,
  output logic [ADDR_WIDTH-1:0] data_wadr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ren,
  output logic [ADDR_WIDTH-1:0] data_radr,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  start,
  input  logic                  done
);
  localparam int CIW = $clog2(NUM_CONFIGS);

  seq_state_e            state_r, state_nx_s;
  logic [ADDR_WIDTH-1:0] cfg_r [NUM_CONFIGS];
  logic [CIW-1:0]        cfg_idx_r;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_nx_s, cnt_max_s;
  logic                  half_r;
  logic [IN_WIDTH-1:0]   lo_r;
  logic                  in_fire_s, hi_fire_s, last_word_s, ser_load_s, ser_last_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  in_rdy_nx_s, instr_wen_nx_s, data_wen_nx_s, data_ren_nx_s, start_nx_s;
  logic [ADDR_WIDTH-1:0] instr_wadr_nx_s, data_wadr_nx_s, data_radr_nx_s;
  logic [DATA_WIDTH-1:0] instr_wdata_nx_s, data_wdata_nx_s;

  assign in_fire_s   = in_vld && in_rdy;
  assign hi_fire_s   = in_fire_s && half_r;
  assign word_s      = DATA_WIDTH'({in_data, lo_r});
  assign last_word_s = (cnt_r == cnt_max_s);
  assign ser_load_s  = (state_r == OUT_WAIT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= CFG;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Word-count limit for the phase currently being walked.
  always_comb begin
    cnt_max_s = '0;
    case (state_r)
      INSTR:    cnt_max_s = cfg_r[CFG_INSTR_MAX];
      INPUT:    cnt_max_s = cfg_r[CFG_IN_MAX];
      OUT_SEND: cnt_max_s = cfg_r[CFG_OUT_MAX];
      default:  cnt_max_s = '0;
    endcase
  end

  // Next-state and word-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      CFG: begin
        if (in_fire_s && (cfg_idx_r == CIW'(NUM_CONFIGS - 1))) begin
          state_nx_s = INSTR;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = CFG;
        end
      end
      INSTR, INPUT: begin
        if (hi_fire_s && last_word_s) begin
          state_nx_s = (state_r == INSTR) ? INPUT : RUN;
          cnt_nx_s   = '0;
        end else if (hi_fire_s) begin
          cnt_nx_s = cnt_r + ADDR_WIDTH'(1);
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      RUN: begin
        if (done) begin
          state_nx_s = OUT_RD;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = RUN;
        end
      end
      OUT_RD:   state_nx_s = OUT_WAIT;
      OUT_WAIT: state_nx_s = OUT_SEND;
      OUT_SEND: begin
        if (ser_last_s && last_word_s) begin
          state_nx_s = INPUT;
          cnt_nx_s   = '0;
        end else if (ser_last_s) begin
          state_nx_s = OUT_RD;
          cnt_nx_s   = cnt_r + ADDR_WIDTH'(1);
        end else begin
          state_nx_s = OUT_SEND;
        end
      end
      default: begin
        state_nx_s = CFG;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Next values of the registered outputs; addresses/data hold when idle.
  always_comb begin
    in_rdy_nx_s      = (state_nx_s == CFG) || (state_nx_s == INSTR) || (state_nx_s == INPUT);
    instr_wen_nx_s   = (state_r == INSTR) && hi_fire_s;
    data_wen_nx_s    = (state_r == INPUT) && hi_fire_s;
    data_ren_nx_s    = (state_nx_s == OUT_RD);
    start_nx_s       = (state_r == INPUT) && (state_nx_s == RUN);
    instr_wadr_nx_s  = instr_wadr;
    instr_wdata_nx_s = instr_wdata;
    data_wadr_nx_s   = data_wadr;
    data_wdata_nx_s  = data_wdata;
    data_radr_nx_s   = data_radr;
    if (instr_wen_nx_s) begin
      instr_wadr_nx_s  = cnt_r;
      instr_wdata_nx_s = word_s;
    end else begin
      instr_wadr_nx_s  = instr_wadr;
    end
    if (data_wen_nx_s) begin
      data_wadr_nx_s  = cfg_r[CFG_IN_OFS] + cnt_r;
      data_wdata_nx_s = word_s;
    end else begin
      data_wadr_nx_s  = data_wadr;
    end
    if (data_ren_nx_s) begin
      data_radr_nx_s = cfg_r[CFG_OUT_OFS] + cnt_nx_s;
    end else begin
      data_radr_nx_s = data_radr;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_rdy      <= 1'b0;
      instr_wen   <= 1'b0;
      instr_wadr  <= '0;
      instr_wdata <= '0;
      data_wen    <= 1'b0;
      data_wadr   <= '0;
      data_wdata  <= '0;
      data_ren    <= 1'b0;
      data_radr   <= '0;
      start       <= 1'b0;
    end else begin
      in_rdy      <= in_rdy_nx_s;
      instr_wen   <= instr_wen_nx_s;
      instr_wadr  <= instr_wadr_nx_s;
      instr_wdata <= instr_wdata_nx_s;
      data_wen    <= data_wen_nx_s;
      data_wadr   <= data_wadr_nx_s;
      data_wdata  <= data_wdata_nx_s;
      data_ren    <= data_ren_nx_s;
      data_radr   <= data_radr_nx_s;
      start       <= start_nx_s;
    end
  end

  // Config slots, word counter and low-half latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONFIGS; i++) cfg_r[i] <= '0;
      cfg_idx_r <= '0;
      cnt_r     <= '0;
      half_r    <= 1'b0;
      lo_r      <= '0;
    end else begin
      cnt_r <= cnt_nx_s;
      if ((state_r == CFG) && in_fire_s) begin
        cfg_r[cfg_idx_r] <= ADDR_WIDTH'(in_data);
        cfg_idx_r        <= cfg_idx_r + CIW'(1);
      end
      if (((state_r == INSTR) || (state_r == INPUT)) && in_fire_s) begin
        half_r <= !half_r;
        if (!half_r) lo_r <= in_data;
      end
    end
  end

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ser_load_s),
    .word_i     (data_rdata),
    .beat_data_o(out_data),
    .beat_vld_o (out_vld),
    .beat_rdy_i (out_rdy),
    .last_o     (ser_last_s)
  );

endmodule

// File: tb/tb_accel_io_sequencer.sv
// Scoreboard bench for accel_io_sequencer: random payloads, expected writes,
// reads and bytes derived from the configured address windows.
module tb_accel_io_sequencer;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] in_data;
  logic          in_vld;
  logic          in_rdy;
  logic [OW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic          instr_wen, data_wen, data_ren;
  logic [AW-1:0] instr_wadr, data_wadr, data_radr;
  logic [DW-1:0] instr_wdata, data_wdata, data_rdata;
  logic          start, done;

  always #5 clk = ~clk;

  accel_io_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .instr_wen(instr_wen), .instr_wadr(instr_wadr), .instr_wdata(instr_wdata),
    .data_wen(data_wen), .data_wadr(data_wadr), .data_wdata(data_wdata),
    .data_ren(data_ren), .data_radr(data_radr), .data_rdata(data_rdata),
    .start(start), .done(done)
  );

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_instr_q[$];
  logic [AW+DW-1:0] exp_dwr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [OW-1:0]    exp_byte_q[$];
  logic [15:0]      cfg_v[5];
  bit  start_allow = 1'b0;
  int  start_cnt   = 0;
  int  frame_id    = 0;
  bit  rdy_toggle  = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents of the result window as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [15:0] a, input int fr);
    if (fr == 1) return 32'hAABB_CCDD;
    return {a ^ 16'(fr * 4951), ~a} + 32'h0F1E_2D3C;
  endfunction

  // Data memory: answers a read one cycle after data_ren, junk otherwise.
  initial begin
    logic        pend_v;
    logic [31:0] pend_w;
    pend_v = 1'b0;
    pend_w = 32'h0;
    data_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      data_rdata = pend_v ? pend_w : $urandom;
      pend_v = data_ren;
      pend_w = mem_word(data_radr, frame_id);
    end
  end

  // Downstream ready: toggling or random.
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_rdy = rdy_toggle ? ~out_rdy : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic [AW+DW-1:0] e;
    logic             prev_stall, prev_start;
    logic [OW-1:0]    prev_byte;
    prev_stall = 1'b0; prev_start = 1'b0; prev_byte = '0;
    forever begin
      @(negedge clk);
      if (instr_wen) begin
        if (exp_instr_q.size() == 0) check("instr_wen_unexpected", 64'(instr_wen), 64'd0);
        else begin
          e = exp_instr_q.pop_front();
          check("instr_write", 64'({instr_wadr, instr_wdata}), 64'(e));
        end
      end
      if (data_wen) begin
        if (exp_dwr_q.size() == 0) check("data_wen_unexpected", 64'(data_wen), 64'd0);
        else begin
          e = exp_dwr_q.pop_front();
          check("data_write", 64'({data_wadr, data_wdata}), 64'(e));
        end
      end
      if (data_ren) begin
        if (exp_rd_q.size() == 0) check("data_ren_unexpected", 64'(data_ren), 64'd0);
        else check("data_read_addr", 64'(data_radr), 64'(exp_rd_q.pop_front()));
      end
      if (prev_stall) check("byte_held", 64'({out_vld, out_data}), 64'({1'b1, prev_byte}));
      if (out_vld && out_rdy) begin
        if (exp_byte_q.size() == 0) check("out_byte_unexpected", 64'(out_vld), 64'd0);
        else check("out_byte", 64'(out_data), 64'(exp_byte_q.pop_front()));
      end
      if (start) begin
        start_cnt++;
        check("start_allowed", 64'(start_allow), 64'd1);
        check("start_width", 64'(prev_start), 64'd0);
      end
      prev_stall = out_vld && !out_rdy;
      prev_byte  = out_data;
      prev_start = start;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_half(input logic [15:0] h);
    int n;
    idle($urandom_range(0, 2));
    in_vld = 1'b1;
    in_data = h;
    n = 0;
    while (!in_rdy && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) check("in_rdy_timeout", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic check_reset_values();
    check("reset_ctrl", 64'({in_rdy, out_vld, out_data, start, instr_wen, data_wen, data_ren}), 64'd0);
    check("reset_addr", 64'({instr_wadr, data_wadr, data_radr}), 64'd0);
    check("reset_wdata", {instr_wdata, data_wdata}, 64'd0);
  endtask

  task automatic load_cfg();
    for (int i = 0; i < 5; i++) send_half(cfg_v[i]);
    check("in_rdy_after_cfg", 64'(in_rdy), 64'd1);
  endtask

  task automatic load_instr();
    logic [31:0] w;
    for (int k = 0; k <= int'(cfg_v[0]); k++) begin
      w = $urandom;
      exp_instr_q.push_back({16'(k), w});
      send_half(w[15:0]);
      send_half(w[31:16]);
    end
    idle(3);
    check("instr_writes_done", 64'(exp_instr_q.size()), 64'd0);
    check("in_rdy_in_input", 64'(in_rdy), 64'd1);
  endtask

  task automatic run_frame(input int hold, input bit stray_done);
    logic [31:0] w;
    logic [15:0] a;
    int n;
    for (int k = 0; k <= int'(cfg_v[1]); k++) begin
      w = $urandom;
      exp_dwr_q.push_back({16'(cfg_v[2] + 16'(k)), w});
      send_half(w[15:0]);
      if (stray_done && k == 1) begin
        done = 1'b1; idle(1); done = 1'b0;
      end
      if (k == int'(cfg_v[1])) start_allow = 1'b1;
      send_half(w[31:16]);
    end
    check("in_rdy_drop", 64'(in_rdy), 64'd0);
    check("start_pulse", 64'(start), 64'd1);
    idle(1);
    check("start_low", 64'(start), 64'd0);
    start_allow = 1'b0;
    check("input_writes_done", 64'(exp_dwr_q.size()), 64'd0);
    in_vld = 1'b1;
    repeat (hold) begin
      in_data = 16'($urandom);
      idle(1);
      check("run_hold", 64'({in_rdy, out_vld}), 64'd0);
    end
    in_vld = 1'b0;
    for (int k = 0; k <= int'(cfg_v[3]); k++) begin
      a = cfg_v[4] + 16'(k);
      exp_rd_q.push_back(a);
      w = mem_word(a, frame_id);
      for (int b = 0; b < 4; b++) exp_byte_q.push_back(w[8*b +: 8]);
    end
    done = 1'b1; idle(1); done = 1'b0;
    n = 0;
    while (exp_byte_q.size() != 0 && n < 5000) begin idle(1); n++; end
    check("output_drained", 64'(exp_byte_q.size()), 64'd0);
    check("reads_done", 64'(exp_rd_q.size()), 64'd0);
    check("in_rdy_back", 64'(in_rdy), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = 16'h0; done = 1'b0;
    idle(3);
    check_reset_values();
    rst_n = 1'b1;
    idle(1);
    check("in_rdy_after_reset", 64'(in_rdy), 64'd1);

    cfg_v[0] = 16'h007D; cfg_v[1] = 16'h0017; cfg_v[2] = 16'h07D0;
    cfg_v[3] = 16'h0017; cfg_v[4] = 16'h07E8;
    load_cfg();
    load_instr();
    frame_id = 1; rdy_toggle = 1'b1;
    run_frame(100, 1'b0);
    frame_id = 2; rdy_toggle = 1'b0;
    run_frame(7, 1'b1);

    // Reset after a lone low half-word: nothing may be written.
    send_half(16'($urandom));
    rst_n = 1'b0;
    idle(1);
    check("in_rdy_in_reset", 64'(in_rdy), 64'd0);
    idle(1);
    check_reset_values();
    rst_n = 1'b1;
    idle(2);

    cfg_v[0] = 16'h0000; cfg_v[1] = 16'h0000; cfg_v[2] = 16'hFFFF;
    cfg_v[3] = 16'($urandom_range(1, 3)); cfg_v[4] = 16'hFFFE;
    load_cfg();
    load_instr();
    frame_id = 3;
    run_frame(0, 1'b0);
    cfg_v[2] = 16'hFFFF;
    frame_id = 4;
    run_frame(3, 1'b0);

    idle(4);
    check("start_count", 64'(start_cnt), 64'd4);
    check("queues_empty", 64'(exp_instr_q.size() + exp_dwr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
